sym_seq_det: RTL and testbench
==============================

// Module: sym_seq_det
// PURPOSE
//  Downstream consumer of 2-bit equality compares: detects a programmed
//   sequence of LEN 2-bit symbols in a valid-qualified symbol stream.
//  Each accepted symbol is compared against the expected pattern symbol.
//   eq2 instances perform all compares; no other comparator logic is used.
//  Emits a 1-cycle match pulse and keeps a saturating match count for
//   status/LED logic.
// PARAMETERS
//  LEN      4              pattern length in symbols, legal range 2..8
//  PATTERN  8'b00_11_01_10 LEN*2 bits; symbol k at [2k+1:2k], k=0 first
//                          default sequence is 10,01,11,00
//  COUNT_W  8              width of match counter
// PORTS
//  clk        in   1        single system clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  clr        in   1        synchronous clear of progress and count
//  sym_in     in   2        input symbol
//  sym_valid  in   1        sym_in is sampled on this clock edge
//  match      out  1        1-cycle pulse: full sequence seen
//  idx        out  $clog2(LEN)  current progress (symbols matched so far)
//  match_cnt  out  COUNT_W  number of matches, saturating
// BEHAVIOUR
//  Reset (reset_n=0, async): idx=0, match=0, match_cnt=0 immediately.
//   Reset mid-sequence discards all progress.
//  Compares (eq2, combinational):
//   hit   = (sym_in == PATTERN[idx])
//   first = (sym_in == PATTERN[0])
//  Per rising edge, priority order:
//   1. clr=1: idx<=0, match<=0, match_cnt<=0. sym_valid is ignored.
//   2. sym_valid=0: idx holds, match<=0, match_cnt holds.
//   3. sym_valid=1, hit=1, idx<LEN-1: idx<=idx+1, match<=0.
//   4. sym_valid=1, hit=1, idx==LEN-1: idx<=0, match<=1,
//      match_cnt<=match_cnt+1 unless all-ones (saturate, no wrap).
//      Non-overlapping: next sequence restarts at symbol 0.
//   5. sym_valid=1, hit=0: idx<=first?1:0, match<=0.
//      A mismatching symbol may start a new attempt.
//  Latency:
//   match is registered; high exactly the cycle after the edge that
//    sampled the last symbol.
//   match_cnt updates on that same edge.
//  Valid gaps of any length between symbols do not break a sequence.
//  match never asserts on two consecutive cycles (LEN>=2).
//  All outputs are registered. No combinational path from inputs to outputs.
// TESTING (default params unless stated)
//  T1 reset:
//   Pulse reset_n low mid-stream after 10,01 ->
//   idx=0, match=0, match_cnt=0 asynchronously.
//   Then 11,00 -> no match.
//  T2 basic:
//   10,01,11,00 on 4 consecutive valid cycles ->
//   match=1 for one cycle after 4th edge; match_cnt=1; idx=0.
//  T3 gaps:
//   Same sequence with 3 sym_valid=0 cycles between each symbol ->
//   exactly one match pulse; idx holds during gaps.
//  T4 restart:
//   10,01,10,01,11,00 -> idx goes 1,2,1,2,3,0; exactly one match;
//   match_cnt=1.
//   Then 11,10 -> idx 0,1.
//  T5 clr priority:
//   After 10,01, assert clr with sym_valid=1, sym_in=11 ->
//   idx=0, match_cnt=0.
//   Following 11,00 -> no match.
//  T6 saturate (COUNT_W=2):
//   Send 5 back-to-back sequences (20 symbols) ->
//   5 match pulses; match_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/sym_seq_det.sv
// Sequence detector over a valid-qualified 2-bit symbol stream.
// All symbol compares go through eq2; match pulse and count are registered.
module eq2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq
);
    assign eq = (a == b);
endmodule

module sym_seq_det #(
    parameter int                LEN     = 4,
    parameter logic [2*LEN-1:0]  PATTERN = 8'b00_11_01_10,
    parameter int                COUNT_W = 8,
    localparam int               IW      = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    output logic               match,
    output logic [IW-1:0]      idx,
    output logic [COUNT_W-1:0] match_cnt
);
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    logic [IW-1:0]      idx_q, idx_d;
    logic               match_q, match_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         exp_sym;
    logic               hit, first;

    always_comb begin
        exp_sym = PATTERN[1:0];
        for (int k = 0; k < LEN; k++) begin
            if (idx_q == k[IW-1:0])
                exp_sym = PATTERN[2*k +: 2];
        end
    end

    eq2 u_hit (
        .a  (sym_in),
        .b  (exp_sym),
        .eq (hit)
    );

    eq2 u_first (
        .a  (sym_in),
        .b  (PATTERN[1:0]),
        .eq (first)
    );

    // A mismatch can itself be the opening symbol of a fresh attempt.
    always_comb begin
        idx_d   = idx_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (clr) begin
            idx_d = '0;
            cnt_d = '0;
        end else if (sym_valid) begin
            if (hit) begin
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    match_d = 1'b1;
                    if (!(&cnt_q))
                        cnt_d = cnt_q + COUNT_W'(1);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                idx_d = first ? IW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign idx       = idx_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_sym_seq_det.sv
// Randomized self-checking bench for sym_seq_det with a sequence model.
// Two instances share stimulus: default counter and a 2-bit counter.
module tb_sym_seq_det;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] sym_in = 2'b00;
    logic       sym_valid = 1'b0;

    logic       d_match, d2_match;
    logic [1:0] d_idx, d2_idx;
    logic [7:0] d_cnt;
    logic [1:0] d2_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int pat [4] = '{2, 1, 3, 0};
    int m_idx = 0;
    bit m_match = 0;
    int m_cnt = 0;
    int m_cnt2 = 0;
    bit prev_match = 0;

    always #5 clk = ~clk;

    sym_seq_det u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .match     (d_match),
        .idx       (d_idx),
        .match_cnt (d_cnt)
    );

    sym_seq_det #(.COUNT_W(2)) u_dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .match     (d2_match),
        .idx       (d2_idx),
        .match_cnt (d2_cnt)
    );

    wire [15:0] obs = {d_idx, d_match, d_cnt, d2_idx, d2_match, d2_cnt};

    function automatic logic [15:0] expv();
        return {2'(m_idx), m_match, 8'(m_cnt), 2'(m_idx), m_match, 2'(m_cnt2)};
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_match = 0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic tick(input bit c, input bit v, input int s);
        @(negedge clk);
        clr = c;
        sym_valid = v;
        sym_in = 2'(s);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (!v) begin
            m_match = 0;
        end else if (s == pat[m_idx]) begin
            if (m_idx == 3) begin
                m_idx = 0;
                m_match = 1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end else begin
                m_idx++;
                m_match = 0;
            end
        end else begin
            m_idx = (s == pat[0]) ? 1 : 0;
            m_match = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs !== 16'h0) begin
            n_err++;
            $display("FAIL reset_init got %h want %h", obs, 16'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) tick(0, 1, pat[i]);
        tick(0, 1, 2);
        tick(0, 1, 1);
        n_cmp++;
        if (obs !== expv() || d_idx !== 2'd2) begin
            n_err++;
            $display("FAIL reset_pre got %h want %h", obs, expv());
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 16'h0) begin
            n_err++;
            $display("FAIL reset_async got %h want %h", obs, 16'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick(0, 1, 3);
        tick(0, 1, 0);
        n_cmp++;
        if (obs !== expv() || d_match !== 1'b0) begin
            n_err++;
            $display("FAIL reset_post got %h want %h", obs, expv());
        end
    endtask

    task automatic test_basic();
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, pat[i]);
            n_cmp++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL basic_step%0d got %h want %h", i, obs, expv());
            end
        end
        n_cmp++;
        if ({d_match, d_cnt, d_idx} !== {1'b1, 8'd1, 2'd0}) begin
            n_err++;
            $display("FAIL basic_match got %h want %h",
                     {d_match, d_cnt, d_idx}, {1'b1, 8'd1, 2'd0});
        end
        tick(0, 0, 0);
        n_cmp++;
        if (d_match !== 1'b0 || d_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL basic_pulse got %b/%0d want 0/1", d_match, d_cnt);
        end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, pat[i]);
            pulses += int'(d_match);
            for (int g = 0; g < 3 && i < 3; g++) begin
                tick(0, 0, $urandom_range(3));
                pulses += int'(d_match);
                n_cmp++;
                if (obs !== expv() || d_idx !== 2'(i + 1)) begin
                    n_err++;
                    $display("FAIL gaps_hold got %h want %h", obs, expv());
                end
            end
        end
        tick(0, 0, 0);
        pulses += int'(d_match);
        n_cmp++;
        if (pulses != 1 || d_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL gaps_pulses got %0d/%0d want 1/1", pulses, d_cnt);
        end
    endtask

    task automatic test_restart();
        int seq_s [8] = '{2, 1, 2, 1, 3, 0, 3, 2};
        int seq_i [8] = '{1, 2, 1, 2, 3, 0, 0, 1};
        int pulses = 0;
        tick(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, seq_s[i]);
            pulses += int'(d_match);
            n_cmp++;
            if (d_idx !== 2'(seq_i[i]) || obs !== expv()) begin
                n_err++;
                $display("FAIL restart_idx%0d got %0d want %0d",
                         i, d_idx, seq_i[i]);
            end
        end
        n_cmp++;
        if (pulses != 1 || d_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL restart_cnt got %0d/%0d want 1/1", pulses, d_cnt);
        end
    endtask

    task automatic test_clr();
        tick(0, 1, 2);
        tick(0, 1, 1);
        tick(1, 1, 3);
        n_cmp++;
        if (d_idx !== 2'd0 || d_cnt !== 8'd0 || d2_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL clr_prio got %0d/%0d want 0/0", d_idx, d_cnt);
        end
        tick(0, 1, 3);
        tick(0, 1, 0);
        n_cmp++;
        if (d_match !== 1'b0 || obs !== expv()) begin
            n_err++;
            $display("FAIL clr_after got %h want %h", obs, expv());
        end
    endtask

    task automatic test_back_to_back();
        int want [5] = '{1, 2, 3, 3, 3};
        int k = 0;
        tick(1, 0, 0);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                tick(0, 1, pat[i]);
                if (d2_match) begin
                    n_cmp++;
                    if (k > 4 || d2_cnt !== 2'(want[k])) begin
                        n_err++;
                        $display("FAIL sat2_cnt%0d got %0d want %0d",
                                 k, d2_cnt, want[k < 5 ? k : 4]);
                    end
                    k++;
                end
            end
        end
        n_cmp++;
        if (k != 5 || d_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL sat2_pulses got %0d/%0d want 5/5", k, d_cnt);
        end
    endtask

    task automatic test_sat8();
        tick(1, 0, 0);
        for (int n = 0; n < 260; n++)
            for (int i = 0; i < 4; i++) tick(0, 1, pat[i]);
        n_cmp++;
        if (d_cnt !== 8'd255 || obs !== expv()) begin
            n_err++;
            $display("FAIL sat8_cnt got %0d want 255", d_cnt);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int s;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(9) < 6) ? pat[m_idx] : int'($urandom_range(3));
            tick($urandom_range(59) == 0, $urandom_range(9) < 7, s);
            if (obs !== expv() || (prev_match && d_match)) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cyc%0d got %h want %h",
                             i, obs, expv());
            end
            prev_match = d_match;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL random_total got %0d bad want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_restart();
        test_clr();
        test_back_to_back();
        test_sat8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
